// File: rtl/bus_source_arbiter.sv
// Registered bus-source arbiter: picks one drive request per cycle and registers the mux select.
// It also provides a hold/lock handshake and counts multi-driver conflicts. Define BUS_ARB_ROUND_ROBIN_EN for rotating priority.
module bus_source_arbiter #(
   parameter int NUM_SRC     = 24,
   parameter int SEL_W       = 5,
   parameter int DEFAULT_SEL = 0,
   parameter int CNT_W       = 8
) (
   input  logic               clk,
   input  logic               clr_n,
   input  logic [NUM_SRC-1:0] src_out,
   input  logic               hold,
   input  logic               cnt_clr,
   output logic [SEL_W-1:0]   sel,
   output logic               sel_valid,
   output logic               conflict,
   output logic [CNT_W-1:0]   conflict_cnt
);

   if (NUM_SRC < 2 || NUM_SRC > 32) begin : g_bad_num_src
      $error("bus_source_arbiter: NUM_SRC must be 2..32");
   end
   if (SEL_W < $clog2(NUM_SRC)) begin : g_bad_sel_w
      $error("bus_source_arbiter: SEL_W too narrow for NUM_SRC");
   end
   if (DEFAULT_SEL < 0 || DEFAULT_SEL >= NUM_SRC) begin : g_bad_default
      $error("bus_source_arbiter: DEFAULT_SEL must name a real source");
   end

   logic [SEL_W-1:0] sel_q, sel_d;
   logic             sel_valid_q, sel_valid_d;
   logic             conflict_q, conflict_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SEL_W-1:0] win;
   logic             found;
   logic             hold_act;

`ifdef BUS_ARB_ROUND_ROBIN_EN
   logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

   // Rotating search starting at rr_ptr; first hit wins.
   always_comb begin
      int idx;
      win   = '0;
      found = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NUM_SRC) idx = idx - NUM_SRC;
         if (!found && src_out[idx]) begin
            found = 1'b1;
            win   = SEL_W'(idx);
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (!hold_act && found)
         rr_ptr_d = (win == SEL_W'(NUM_SRC - 1)) ? '0 : win + 1'b1;
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) rr_ptr_q <= '0;
      else        rr_ptr_q <= rr_ptr_d;
   end
`else
   // Descending scan so the lowest set index is the last one written.
   always_comb begin
      win   = '0;
      found = |src_out;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (src_out[i]) win = SEL_W'(i);
      end
   end
`endif

   always_comb begin
      hold_act    = hold & sel_valid_q;
      sel_d       = sel_q;
      sel_valid_d = sel_valid_q;
      if (!hold_act) begin
         sel_valid_d = found;
         if (found) sel_d = win;
      end
      // Clearing the lowest set bit leaves something only if two or more were set.
      conflict_d = |(src_out & (src_out - NUM_SRC'(1)));
      cnt_d      = cnt_q;
      if (cnt_clr)                    cnt_d = '0;
      else if (conflict_d && ~&cnt_q) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         sel_q       <= SEL_W'(DEFAULT_SEL);
         sel_valid_q <= 1'b0;
         conflict_q  <= 1'b0;
         cnt_q       <= '0;
      end else begin
         sel_q       <= sel_d;
         sel_valid_q <= sel_valid_d;
         conflict_q  <= conflict_d;
         cnt_q       <= cnt_d;
      end
   end

   assign sel          = sel_q;
   assign sel_valid    = sel_valid_q;
   assign conflict     = conflict_q;
   assign conflict_cnt = cnt_q;

endmodule
